thirty_two_bit_adder: RTL and testbench

THIRTY_TWO_BIT_ADDER -- requirements
Module: thirty_two_bit_adder

---
 rtl/adder_pkg.sv | 13 +
 rtl/cla4_block.sv | 50 +++++
 rtl/thirty_two_bit_adder.sv | 58 +++++
 tb/tb_thirty_two_bit_adder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the registered 32-bit carry-lookahead adder.
// Operand width and lookahead group size are kept here so the top and its sub-block agree.
package adder_pkg;

   localparam int ADDER_WIDTH = 32;
   localparam int CLA_GROUP   = 4;

   // Number of lookahead groups needed to cover a given operand width.
   function automatic int numGroups(input int width);
      return width / CLA_GROUP;
   endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead group: full internal lookahead, plus group propagate/generate terms.
// Carries c1..c4 are flattened sum-of-products so no carry ripples inside the group.
module cla4_block
   import adder_pkg::*;
(
   input  logic [CLA_GROUP-1:0] a,
   input  logic [CLA_GROUP-1:0] b,
   input  logic                 ci,
   output logic [CLA_GROUP-1:0] s,
   output logic                 co,
   output logic                 P,
   output logic                 G
);

   logic [CLA_GROUP-1:0] w_p;
   logic [CLA_GROUP-1:0] w_g;
   logic                 w_c1;
   logic                 w_c2;
   logic                 w_c3;
   logic                 w_c4;

   assign w_p = a ^ b;
   assign w_g = a & b;

   assign w_c1 = w_g[0]
               | (w_p[0] & ci);
   assign w_c2 = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & ci);
   assign w_c3 = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
   assign w_c4 = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

   assign s  = w_p ^ {w_c3, w_c2, w_c1, ci};
   assign co = w_c4;

   // Group terms are independent of ci so a higher lookahead level could consume them.
   assign P = &w_p;
   assign G = w_g[3]
            | (w_p[3] & w_g[2])
            | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/thirty_two_bit_adder.sv
// Registered unsigned adder: {Cout,S} <= A + B + Cin with one cycle of latency.
// Eight 4-bit lookahead groups ripple their carries; synchronous reset clears the result.
module thirty_two_bit_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int NUM_GROUPS = numGroups(WIDTH);

   logic [NUM_GROUPS:0]   w_carry;
   logic [WIDTH-1:0]      w_sum;
   logic [NUM_GROUPS-1:0] w_grpP;
   logic [NUM_GROUPS-1:0] w_grpG;
   logic                  w_unusedGrpPg;
   logic [WIDTH-1:0]      r_sum;
   logic                  r_cout;

   assign w_carry[0] = Cin;

   for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_cla
      cla4_block u_cla4 (
         .a  (A[gi*CLA_GROUP +: CLA_GROUP]),
         .b  (B[gi*CLA_GROUP +: CLA_GROUP]),
         .ci (w_carry[gi]),
         .s  (w_sum[gi*CLA_GROUP +: CLA_GROUP]),
         .co (w_carry[gi+1]),
         .P  (w_grpP[gi]),
         .G  (w_grpG[gi])
      );
   end

   // Groups are chained through their carry-out, so the group P/G terms are not needed here.
   assign w_unusedGrpPg = ^{w_grpP, w_grpG};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_carry[NUM_GROUPS];
      end
   end

   assign S    = r_sum;
   assign Cout = r_cout;

endmodule

// File: tb/tb_thirty_two_bit_adder.sv
// Self-checking bench for thirty_two_bit_adder: directed corner cases, reset behaviour,
// and back-to-back random operands compared against a plain 33-bit arithmetic model.
module tb_thirty_two_bit_adder;

   logic        clk;
   logic        rst;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        carryIn;
   logic [31:0] sum;
   logic        carryOut;

   int vectors;
   int miscompares;

   thirty_two_bit_adder #(.WIDTH(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (opA),
      .B    (opB),
      .Cin  (carryIn),
      .S    (sum),
      .Cout (carryOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the exact 33-bit unsigned sum.
   function automatic logic [32:0] refSum(input logic [31:0] a, input logic [31:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + {32'd0, cin};
   endfunction

   // Drive at the falling edge, then let one rising edge register it and settle.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic rstVal);
      @(negedge clk);
      opA     = a;
      opB     = b;
      carryIn = cin;
      rst     = rstVal;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
         vectors++;
         if ({carryOut, sum} !== 33'd0) begin
            miscompares++;
            $display("[TB] FAIL reset[%0d]: got Cout=%0b S=%h, want Cout=0 S=00000000", i, carryOut, sum);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] tA   [12];
      logic [31:0] tB   [12];
      logic        tCin [12];
      logic [32:0] tExp [12];
      tA   = '{32'd0, 32'd2, 32'd15, 32'd20, 32'd44, 32'd500, 32'd46331,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      tB   = '{32'd0, 32'd5, 32'd45, 32'd13, 32'd99, 32'd16335, 32'd30004,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd0};
      tCin = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tExp = '{33'd0, 33'd8, 33'd60, 33'd34, 33'd143, 33'd16835, 33'd76335,
               {1'b1, 32'hFFFFFFFE}, {1'b1, 32'hFFFFFFFF}, {1'b1, 32'h00000000},
               {1'b1, 32'h00000000}, {1'b0, 32'h80000000}};
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tA[i], tB[i], tCin[i], 1'b0);
         vectors++;
         if ({carryOut, sum} !== tExp[i]) begin
            miscompares++;
            $display("[TB] FAIL directed[%0d] %h+%h+%0b: got Cout=%0b S=%h, want Cout=%0b S=%h",
                     i, tA[i], tB[i], tCin[i], carryOut, sum, tExp[i][32], tExp[i][31:0]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      applyStimulus(32'd1234, 32'd4321, 1'b0, 1'b0);
      applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
      vectors++;
      if ({carryOut, sum} !== 33'd0) begin
         miscompares++;
         $display("[TB] FAIL midstream_reset: got Cout=%0b S=%h, want Cout=0 S=00000000", carryOut, sum);
      end
      applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
      vectors++;
      if ({carryOut, sum} !== {1'b1, 32'h00000000}) begin
         miscompares++;
         $display("[TB] FAIL after_reset: got Cout=%0b S=%h, want Cout=1 S=00000000", carryOut, sum);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [32:0] expected;
      for (int i = 0; i < 1000; i++) begin
         a   = $urandom;
         b   = $urandom;
         cin = 1'($urandom_range(0, 1));
         if (i % 10 == 0) a = 32'hFFFFFFFF - b;
         expected = refSum(a, b, cin);
         applyStimulus(a, b, cin, 1'b0);
         vectors++;
         if ({carryOut, sum} !== expected) begin
            miscompares++;
            $display("[TB] FAIL random[%0d] %h+%h+%0b: got Cout=%0b S=%h, want Cout=%0b S=%h",
                     i, a, b, cin, carryOut, sum, expected[32], expected[31:0]);
         end
         // Result must hold until the next rising edge even though inputs change at negedge.
         if (i % 50 == 0) begin
            @(negedge clk);
            opA = ~a;
            opB = ~b;
            #3;
            vectors++;
            if ({carryOut, sum} !== expected) begin
               miscompares++;
               $display("[TB] FAIL hold[%0d]: got Cout=%0b S=%h, want Cout=%0b S=%h",
                        i, carryOut, sum, expected[32], expected[31:0]);
            end
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      opA         = '0;
      opB         = '0;
      carryIn     = 1'b0;
      $display("[TB] starting thirty_two_bit_adder bench");
      test_reset();
      test_directed();
      test_reset_midstream();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
